data_mem_responder: RTL
=======================

Name: data_mem_responder

Overview:
Responder end of the pipeline's data-memory interface. It accepts load/store requests from the MEM stage over a valid/ready handshake and performs RV32 byte/half/word accesses on an internal word-organised RAM. It returns each result after a programmable number of wait states. It replaces the zero-latency data memory, so the core can be exercised against realistic memory timing.

Parameters:
ADDR_WIDTH, 10, word-address bits; RAM depth = 2**ADDR_WIDTH words (4 KiB at default)
LATENCY, 2, cycles from request accept to response valid; legal range 1..15

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
req_valid  input  1  request present
req_ready  output  1  responder can accept a request
req_we  input  1  1 = store, 0 = load
req_funct3  input  3  RV32 size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
req_addr  input  32  byte address
req_wdata  input  32  store data, right-aligned
rsp_valid  output  1  response present
rsp_ready  input  1  requester accepts response
rsp_rdata  output  32  load data, extended per funct3; 0 for stores
rsp_err  output  1  error flag (see Optional Feature; 0 otherwise)

Behaviour:
- Reset (reset=0, async): state IDLE, req_ready=0 while asserted then 1 on first clk after release, rsp_valid=0, rsp_rdata=0, rsp_err=0, latency counter=0. RAM contents are not cleared. An in-flight transaction is dropped and a pending store is not performed.
- FSM states: IDLE, WAIT, RESP.
- IDLE: req_ready=1. On req_valid&req_ready, latch we/funct3/addr/wdata, load counter=LATENCY-1, go to WAIT.
- WAIT: req_ready=0. Counter decrements each cycle. In the cycle the counter is 0, perform the access, register rsp_rdata/rsp_err, go to RESP.
- RESP: rsp_valid=1 and outputs held stable until rsp_ready=1. On rsp_valid&rsp_ready, go to IDLE. rsp_valid deasserts in the next cycle.
- Latency: with rsp_ready tied high, rsp_valid rises exactly LATENCY cycles after the accept edge. One outstanding transaction at a time. Throughput is 1 request per LATENCY+2 cycles.
- Addressing: word index = req_addr[ADDR_WIDTH+1:2]. Upper address bits are ignored, so addresses wrap modulo RAM size. Byte lane = req_addr[1:0].
- Loads: B/BU select lane addr[1:0]; H/HU select the half addr[1]. B/H sign-extend from bit 7/15; BU/HU zero-extend. W returns the full word.
- Stores: byte-enable write. SB writes lane addr[1:0] with wdata[7:0]. SH writes half addr[1] with wdata[15:0]. SW writes all 4 bytes. Other bytes are unchanged.
- Misaligned accesses (H at addr[0]=1, W at addr[1:0]!=0), without the feature: the low address bits are forced to alignment and the access proceeds.
- Illegal funct3 (011, 110, 111): treated as W.
- req_valid while not ready: ignored; the requester must hold it. rsp_ready while not RESP: ignored.

Optional Feature:
Macro DATA_MEM_MISALIGN_ERR_EN.
- Defined: a misaligned H/HU/W access or an illegal funct3 performs no RAM write and returns rsp_rdata=0, rsp_err=1 with the normal latency.
- Undefined: rsp_err is tied 0 and the alignment forcing above applies.

Decomposition:
- Shared package holds: funct3 size constants (F3_LB..F3_LHU), FSM state encoding, and MEM_LATENCY_MAX=15.
- One sub-module, data_mem_lane_ctrl (combinational), generates the 4-bit byte-enable and write data from funct3/addr/wdata. It also performs load extraction and sign extension.
- FSM, counter and RAM stay in the top.

Test Plan:
- Reset then SW addr 0x00000010 data 0xDEADBEEF, LATENCY=2, rsp_ready=1 -> rsp_valid exactly 2 cycles after accept with rsp_rdata=0. LW 0x10 -> 0xDEADBEEF.
- SB 0x11 data 0x000000A5 over 0xDEADBEEF -> LW 0x10 = 0xDEADA5EF. LB 0x11 = 0xFFFFFFA5. LBU 0x11 = 0x000000A5.
- SH 0x12 data 0x00008001 -> LH 0x12 = 0xFFFF8001, LHU 0x12 = 0x00008001, and lower half unchanged.
- Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_valid and rsp_rdata stable, req_ready=0 throughout. After the handshake, req_ready=1 the next cycle.
- Wrap: SW addr 0x00001010 (ADDR_WIDTH=10) data 0x12345678 -> LW 0x10 returns 0x12345678.
- Reset asserted in WAIT during SW 0x20 data 0xFFFFFFFF (prior 0) -> rsp_valid never rises. After release LW 0x20 = 0. With the macro defined, LW 0x22 -> rsp_err=1, rsp_rdata=0.

Source files
------------

// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the data-memory responder: RV32 access-size codes,
// FSM state encoding and the wait-state bound.
package data_mem_responder_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam int MEM_LATENCY_MAX = 15;
  localparam int CNT_W = $clog2(MEM_LATENCY_MAX + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_e;

  typedef enum logic [1:0] {
    SZ_BYTE,
    SZ_HALF,
    SZ_WORD
  } size_e;

  // Unused funct3 codes fall through to a word access.
  function automatic size_e decodeSize(input logic [2:0] f3);
    case (f3)
      F3_LB, F3_LBU: decodeSize = SZ_BYTE;
      F3_LH, F3_LHU: decodeSize = SZ_HALF;
      default:       decodeSize = SZ_WORD;
    endcase
  endfunction

  function automatic logic isBadAccess(input logic [2:0] f3, input logic [1:0] addrLo);
    case (f3)
      F3_LB, F3_LBU: isBadAccess = 1'b0;
      F3_LH, F3_LHU: isBadAccess = addrLo[0];
      F3_LW:         isBadAccess = (addrLo != 2'b00);
      default:       isBadAccess = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/data_mem_lane_ctrl.sv
// Byte-lane steering for RV32 sub-word accesses: store byte enables/data and
// load extraction with sign/zero extension. DATA_MEM_MISALIGN_ERR_EN flags bad accesses.
module data_mem_lane_ctrl
  import data_mem_responder_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addrLo_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rword_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o,
  output logic        err_o
);

  size_e       size;
  logic [7:0]  byteSel;
  logic [15:0] halfSel;

  // Half accesses only look at addr[1], which is what forces alignment.
  always_comb begin
    size    = decodeSize(funct3_i);
    byteSel = rword_i[{addrLo_i, 3'b000} +: 8];
    halfSel = addrLo_i[1] ? rword_i[31:16] : rword_i[15:0];
    be_o    = 4'b1111;
    wdata_o = wdata_i;
    rdata_o = rword_i;
    err_o   = 1'b0;
    case (size)
      SZ_BYTE: begin
        be_o    = 4'b0001 << addrLo_i;
        wdata_o = {4{wdata_i[7:0]}};
        rdata_o = funct3_i[2] ? {24'b0, byteSel} : {{24{byteSel[7]}}, byteSel};
      end
      SZ_HALF: begin
        be_o    = addrLo_i[1] ? 4'b1100 : 4'b0011;
        wdata_o = {2{wdata_i[15:0]}};
        rdata_o = funct3_i[2] ? {16'b0, halfSel} : {{16{halfSel[15]}}, halfSel};
      end
      default: ;
    endcase
`ifdef DATA_MEM_MISALIGN_ERR_EN
    if (isBadAccess(funct3_i, addrLo_i)) begin
      be_o    = 4'b0000;
      rdata_o = '0;
      err_o   = 1'b1;
    end
`endif
  end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: valid/ready load/store port onto a word RAM with LATENCY
// wait states. Define DATA_MEM_MISALIGN_ERR_EN to report misaligned/illegal accesses.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  ready_q;
  logic                  we_q;
  logic [2:0]            funct3_q;
  logic [ADDR_WIDTH+1:0] addr_q;
  logic [31:0]           wdata_q;
  logic [31:0]           rdata_q, rdata_d;
  logic                  err_q, err_d;

  logic [31:0] mem [DEPTH];

  logic        accept;
  logic        access;
  logic [31:0] rword;
  logic [3:0]  laneBe;
  logic [31:0] laneWdata;
  logic [31:0] laneRdata;
  logic        laneErr;
  logic        unusedAddrHi;

  // Upper address bits are dropped so accesses wrap modulo the RAM size.
  assign unusedAddrHi = ^req_addr[31:ADDR_WIDTH+2];

  assign accept = req_valid && ready_q;
  assign access = (state_q == ST_WAIT) && (cnt_q == '0);
  assign rword  = mem[addr_q[ADDR_WIDTH+1:2]];

  data_mem_lane_ctrl u_lane (
    .funct3_i (funct3_q),
    .addrLo_i (addr_q[1:0]),
    .wdata_i  (wdata_q),
    .rword_i  (rword),
    .be_o     (laneBe),
    .wdata_o  (laneWdata),
    .rdata_o  (laneRdata),
    .err_o    (laneErr)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_WAIT;
          cnt_d   = CNT_LOAD;
        end
      end
      ST_WAIT: begin
        if (access) begin
          state_d = ST_RESP;
          rdata_d = we_q ? 32'h0 : laneRdata;
          err_d   = laneErr;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Ready is registered so it stays low throughout reset and rises one clock after release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      ready_q  <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      we_q     <= 1'b0;
      funct3_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= (state_d == ST_IDLE);
      rdata_q <= rdata_d;
      err_q   <= err_d;
      if (accept) begin
        we_q     <= req_we;
        funct3_q <= req_funct3;
        addr_q   <= req_addr[ADDR_WIDTH+1:0];
        wdata_q  <= req_wdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (access && we_q) begin
      for (int b = 0; b < 4; b++) begin
        if (laneBe[b]) mem[addr_q[ADDR_WIDTH+1:2]][8*b +: 8] <= laneWdata[8*b +: 8];
      end
    end
  end

  assign req_ready = ready_q;
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule
